// File: rtl/pipe_skid_fifo_pkg.sv
// Shared sizing helpers for pipe_skid_fifo and its skid ring.
// Ring pointer/count and level types are declared per instance from these widths.
package pipe_skid_fifo_pkg;

    function automatic int unsigned ptr_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Total occupancy spans 0..DEPTH+1 (output stage plus full ring).
    function automatic int unsigned lvl_bits(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipe_skid_fifo_ring.sv
// DEPTH x DWIDTH skid ring: naturally wrapping pointers plus a separate count.
module pipe_skid_fifo_ring
    import pipe_skid_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DWIDTH-1:0]           i_wdata,
    output logic [DWIDTH-1:0]           o_rdata,
    output logic [cnt_bits(DEPTH)-1:0]  o_count,
    output logic                        o_empty,
    output logic                        o_full
);

    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam int unsigned CW = cnt_bits(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    cnt_t              r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; the count alone defines validity.
    always_ff @(posedge i_clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == cnt_t'(DEPTH));

endmodule

// File: rtl/pipe_skid_fifo.sv
// Elastic valid/ready buffer: registered output stage backed by a DEPTH-entry skid ring.
// Define PIPE_SKID_FIFO_LEVEL_EN to add the o_count / o_almost_full level outputs.
module pipe_skid_fifo
    import pipe_skid_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AFULL  = DEPTH
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [DWIDTH-1:0]           i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    output logic [DWIDTH-1:0]           o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready
`ifdef PIPE_SKID_FIFO_LEVEL_EN
    ,
    output logic [lvl_bits(DEPTH)-1:0]  o_count,
    output logic                        o_almost_full
`endif
);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("pipe_skid_fifo: DEPTH must be a power of two, at least 2");
    end
    if ((AFULL < 1) || (AFULL > DEPTH + 1)) begin : g_bad_afull
        $error("pipe_skid_fifo: AFULL must lie in 1..DEPTH+1");
    end

    typedef logic [cnt_bits(DEPTH)-1:0] cnt_t;
    localparam cnt_t RingDepth = cnt_t'(DEPTH);

    logic              r_valid;
    logic              r_ready;
    logic [DWIDTH-1:0] r_data;

    logic              w_in_xfer;
    logic              w_ld;
    logic              w_push;
    logic              w_pop;
    logic              w_valid_nxt;
    logic              w_ring_empty;
    logic              w_ring_full;
    logic [DWIDTH-1:0] w_ring_rdata;
    cnt_t              w_ring_cnt;
    cnt_t              w_ring_cnt_nxt;

    assign w_in_xfer   = i_data_valid & r_ready;
    assign w_ld        = ~r_valid | i_data_ready;
    assign w_pop       = w_ld & ~w_ring_empty;
    // Incoming word bypasses the ring only when the stage loads from an empty ring.
    assign w_push      = w_in_xfer & ~(w_ld & w_ring_empty);
    assign w_valid_nxt = w_ld ? (~w_ring_empty | w_in_xfer) : r_valid;
    assign w_ring_cnt_nxt = w_ring_cnt + cnt_t'(w_push) - cnt_t'(w_pop);

    pipe_skid_fifo_ring #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ring (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (i_data),
        .o_rdata (w_ring_rdata),
        .o_count (w_ring_cnt),
        .o_empty (w_ring_empty),
        .o_full  (w_ring_full)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ready <= (w_ring_cnt_nxt < RingDepth);
            if (w_ld) begin
                if (!w_ring_empty) begin
                    r_data <= w_ring_rdata;
                end else if (w_in_xfer) begin
                    r_data <= i_data;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            assert (!(w_push && w_ring_full)) else $error("pipe_skid_fifo: push into full ring");
        end
    end

    assign o_data_ready = r_ready;
    assign o_data_valid = r_valid;
    assign o_data       = r_data;

`ifdef PIPE_SKID_FIFO_LEVEL_EN
    typedef logic [lvl_bits(DEPTH)-1:0] lvl_t;

    lvl_t r_count;
    logic r_almost_full;
    lvl_t w_level_nxt;

    assign w_level_nxt = lvl_t'(w_valid_nxt) + lvl_t'(w_ring_cnt_nxt);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= lvl_t'(AFULL));
        end
    end

    assign o_count       = r_count;
    assign o_almost_full = r_almost_full;
`endif

endmodule
